// File: rtl/ysyx_201979054_load_unit.sv
// Load unit: fetches the aligned doubleword, extracts the addressed field and extends it.
// Optional misaligned-load trap enabled by defining LOAD_MISALIGN_CHECK_EN.
module ysyx_201979054_load_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_funct3,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
    output logic                  o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;

`ifdef LOAD_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic start_misalign;

    // Misalignment of the incoming request, judged on the live inputs
    always_comb begin
        start_misalign = 1'b0;
        unique case (i_funct3)
            3'b001, 3'b101: start_misalign = i_addr[0];
            3'b010, 3'b110: start_misalign = |i_addr[1:0];
            3'b011:         start_misalign = |i_addr[2:0];
            default:        start_misalign = 1'b0;
        endcase
    end

    assign o_misalign = misalign_q;
`else
    assign o_misalign = 1'b0;
`endif

    // Byte lanes above offset 7 shift in as zero
    assign shifted = i_mem_resp_data >> {addr_q[2:0], 3'b000};

    // Field selection and sign/zero extension
    always_comb begin
        ext = '0;
        unique case (funct3_q)
            3'b000: ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001: ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010: ext = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b011: ext = shifted;
            3'b100: ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101: ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            3'b110: ext = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
            default: ext = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
`ifdef LOAD_MISALIGN_CHECK_EN
                    state_d = start_misalign ? S_DONE : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ:  if (i_mem_req_ready) state_d = S_WAIT;
            S_WAIT: if (i_mem_resp_valid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        o_busy          = (state_q != S_IDLE);
        o_done          = (state_q == S_DONE);
        o_mem_req_valid = (state_q == S_REQ);
    end

    // Request latch and result capture
    always_comb begin
        addr_d   = addr_q;
        funct3_d = funct3_q;
        data_d   = data_q;
`ifdef LOAD_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        if (state_q == S_IDLE && i_start) begin
            addr_d   = i_addr;
            funct3_d = i_funct3;
`ifdef LOAD_MISALIGN_CHECK_EN
            misalign_d = start_misalign;
            if (start_misalign) data_d = '0;
`endif
        end else if (state_q == S_WAIT && i_mem_resp_valid) begin
            data_d = ext;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            funct3_q <= '0;
            data_q   <= '0;
`ifdef LOAD_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            data_q   <= data_d;
`ifdef LOAD_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign o_mem_addr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign o_load_data = data_q;

endmodule

// File: tb/tb_ysyx_201979054_load_unit.sv
// Scoreboard bench for the load unit with a byte-level reference model.
// Honours LOAD_MISALIGN_CHECK_EN when the design is built with it.
module tb_ysyx_201979054_load_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [63:0] i_addr = '0;
    logic [2:0]  i_funct3 = '0;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_load_data;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [63:0] o_mem_addr;
    logic        i_mem_resp_valid = 1'b0;
    logic [63:0] i_mem_resp_data = '0;
    logic        o_misalign;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] mem_addr;
        logic [63:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];

`ifdef LOAD_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    ysyx_201979054_load_unit #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_addr(i_addr),
        .i_funct3(i_funct3),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_load_data(o_load_data),
        .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready),
        .o_mem_addr(o_mem_addr),
        .i_mem_resp_valid(i_mem_resp_valid),
        .i_mem_resp_data(i_mem_resp_data),
        .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: gather bytes from the doubleword, zero beyond byte 7, then extend
    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f3,
                                             input logic [63:0] d, output bit mis);
        int size;
        bit sgn;
        int off;
        logic [63:0] r;
        off = int'(a[2:0]);
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 1; end
            3'd3: begin size = 8; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            3'd6: begin size = 4; sgn = 0; end
            default: begin size = 0; sgn = 0; end
        endcase
        mis = (size > 1) && ((off % size) != 0);
        r = '0;
        for (int k = 0; k < size; k++) begin
            if (off + k < 8) r[8*k +: 8] = d[8*(off+k) +: 8];
        end
        if (sgn && size < 8 && r[8*size-1]) begin
            for (int b = 8*size; b < 64; b++) r[b] = 1'b1;
        end
        return r;
    endfunction

    // Monitor: address stability while requesting, result on every completion
    always @(negedge clk) begin
        if (!rst) begin
            if (o_mem_req_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", o_mem_addr);
                end else begin
                    check("mem_addr", o_mem_addr, sb[0].mem_addr);
                end
            end
            if (o_done) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("load_data", o_load_data, e.data);
                    check("misalign", {63'b0, o_misalign}, {63'b0, e.mis});
                end
            end
        end
    end

    task automatic do_load(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] rdata,
                           input int rdly, input int vdly, input bit spurious);
        exp_t e;
        bit mis;
        bit trap;
        int c;
        int nreq;
        int exp_lat;
        bit got;
        e.data = ref_load(a, f3, rdata, mis);
        trap = CHK_EN && mis;
        if (trap) e.data = '0;
        e.mis = trap;
        e.mem_addr = a & ~64'h7;
        sb.push_back(e);
        exp_lat = trap ? 1 : 3 + rdly + vdly;
        i_start = 1'b1;
        i_addr = a;
        i_funct3 = f3;
        @(posedge clk); #1;
        i_addr = {$urandom, $urandom};
        i_funct3 = 3'($urandom);
        c = 1;
        nreq = 0;
        got = 0;
        while (!got && c <= 60) begin
            i_start = spurious && !trap && (c == 2 + rdly);
            i_mem_req_ready = (c == 1 + rdly);
            i_mem_resp_valid = (c == 2 + rdly + vdly);
            i_mem_resp_data = i_mem_resp_valid ? rdata : {$urandom, $urandom};
            @(negedge clk);
            if (o_mem_req_valid) nreq++;
            if (o_done) got = 1;
            else begin
                @(posedge clk); #1;
                c++;
            end
        end
        i_start = 1'b0;
        i_mem_req_ready = 1'b0;
        i_mem_resp_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout: got no done expected done at cycle %0d", exp_lat);
        end else begin
            check("latency", 64'(c), 64'(exp_lat));
            check("req_cycles", 64'(nreq), trap ? 64'd0 : 64'(rdly + 1));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'b0, o_busy}, 64'd0);
        check("rst_done", {63'b0, o_done}, 64'd0);
        check("rst_reqv", {63'b0, o_mem_req_valid}, 64'd0);
        check("rst_mis", {63'b0, o_misalign}, 64'd0);
        check("rst_data", o_load_data, 64'd0);
        check("rst_addr", o_mem_addr, 64'd0);
        @(posedge clk); #1;

        do_load(64'h1003, 3'b000, 64'h0000_0000_8000_0000, 0, 0, 0);
        do_load(64'h2004, 3'b110, 64'h8765_4321_0000_0000, 0, 0, 0);
        do_load(64'h3000, 3'b011, 64'hDEAD_BEEF_CAFE_F00D, 4, 0, 0);
        do_load(64'h4008, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 0);
        do_load(64'h1002, 3'b010, 64'h8899_AABB_CCDD_EEFF, 0, 0, 0);
        do_load(64'h5007, 3'b001, 64'h80FF_0000_0000_0000, 0, 1, 0);

        // Start pulsed during WAIT must not spawn a second completion
        do_load(64'h6010, 3'b010, 64'h0000_0000_F000_0001, 1, 3, 1);
        repeat (8) begin
            @(negedge clk);
            check("idle_after_spurious", {63'b0, o_busy}, 64'd0);
        end
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            do_load({$urandom, $urandom}, 3'($urandom), {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Reset in WAIT, then a stale response
        begin
            exp_t e;
            e.mem_addr = 64'h7000;
            e.data = '0;
            e.mis = 1'b0;
            sb.push_back(e);
        end
        i_start = 1'b1;
        i_addr = 64'h7000;
        i_funct3 = 3'b011;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check("rstwait_busy", {63'b0, o_busy}, 64'd0);
        check("rstwait_data", o_load_data, 64'd0);
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rstwait_done", {63'b0, o_done}, 64'd0);
            check("rstwait_data_hold", o_load_data, 64'd0);
        end
        @(posedge clk); #1;

        do_load(64'h8001, 3'b100, 64'h0000_0000_0000_9A00, 0, 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_201979054_load_unit.md
YSYX_201979054_LOAD_UNIT -- requirements
Module: ysyx_201979054_load_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, which sets the width of the memory data and load result.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, which sets the width of the byte address.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have port i_start, input, 1 bit: load request from the control FSM.
REQ-006 SHALL have port i_addr, input, ADDR_WIDTH bits: byte address of the load.
REQ-007 SHALL have port i_funct3, input, 3 bits: load type, 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-008 SHALL have port o_busy, input side of control, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port o_done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port o_load_data, output, DATA_WIDTH bits: extended load result, feeding the result-select mux.
REQ-011 SHALL have port o_mem_req_valid, output, 1 bit: memory read request valid.
REQ-012 SHALL have port i_mem_req_ready, input, 1 bit: memory accepts the request.
REQ-013 SHALL have port o_mem_addr, output, ADDR_WIDTH bits: doubleword-aligned address, i.e. {addr[ADDR_WIDTH-1:3], 3'b000}.
REQ-014 SHALL have port i_mem_resp_valid, input, 1 bit: read data valid.
REQ-015 SHALL have port i_mem_resp_data, input, DATA_WIDTH bits: aligned doubleword read data.
REQ-016 SHALL have port o_misalign, output, 1 bit: misaligned-load flag, valid while o_done is high.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-018 In IDLE, i_start=1 SHALL latch i_addr and i_funct3 and move to REQ; i_start SHALL be ignored in all other states.
REQ-019 In REQ, o_mem_req_valid SHALL be 1 and o_mem_addr SHALL be held stable; on i_mem_req_ready=1 the FSM SHALL move to WAIT.
REQ-020 In WAIT, i_mem_resp_valid=1 SHALL capture the extracted and extended data into o_load_data and move the FSM to DONE.
REQ-021 i_mem_resp_valid SHALL be ignored outside WAIT.
REQ-022 In DONE, o_done SHALL be 1 for exactly one cycle, followed by a return to IDLE.
REQ-023 Minimum latency, with ready and response each given on first opportunity, SHALL be start edge to o_done high = 3 cycles.
REQ-024 Extraction: the selected field SHALL be i_mem_resp_data shifted right by 8*addr[2:0], then the low 8, 16, 32 or 64 bits taken.
REQ-025 LB, LH and LW SHALL be sign-extended to DATA_WIDTH; LBU, LHU and LWU SHALL be zero-extended; LD SHALL pass through.
REQ-026 i_funct3=111 SHALL complete normally with o_load_data=0.
REQ-027 o_load_data SHALL hold its value until the next capture; it SHALL not be changed by a misaligned completion unless REQ-033 applies.
REQ-028 o_mem_req_valid SHALL never be deasserted before the request handshake completes.

Reset
REQ-029 rst=1 SHALL force the FSM to IDLE on the next edge, from any state, including mid-request and mid-wait.
REQ-030 After reset, o_busy, o_done, o_mem_req_valid, o_misalign, o_load_data and o_mem_addr SHALL all be 0.
REQ-031 A response arriving after reset SHALL be ignored, because the FSM is in IDLE.

Configuration
REQ-032 The macro LOAD_MISALIGN_CHECK_EN SHALL select the misalignment check.
REQ-033 With LOAD_MISALIGN_CHECK_EN defined, a misaligned start SHALL go IDLE->DONE with no memory request, o_misalign=1 and o_load_data=0.
REQ-034 A start is misaligned when it is LH/LHU with addr[0]!=0, LW/LWU with addr[1:0]!=0, or LD with addr[2:0]!=0.
REQ-035 Without the macro, o_misalign SHALL be tied to 0, and misaligned loads SHALL proceed with the shift of REQ-024, taking bytes above offset 7 as 0.

Verification
REQ-036 Bench SHALL cover: LB with addr=0x1003, resp=0x0000_0000_8000_0000 -> o_mem_addr=0x1000, o_load_data=0xFFFF_FFFF_FFFF_FF80.
REQ-037 Bench SHALL cover: LWU with addr=0x2004, resp=0x8765_4321_0000_0000 -> o_load_data=0x0000_0000_8765_4321.
REQ-038 Bench SHALL cover: LD with addr=0x3000, ready held 0 for 4 cycles -> o_mem_req_valid and o_mem_addr stable throughout, o_done 7 cycles after start.
REQ-039 Bench SHALL cover: rst pulsed during WAIT, then resp_valid=1 -> FSM in IDLE, o_done stays 0, o_load_data=0.
REQ-040 Bench SHALL cover, with the macro defined: LW with addr=0x1002 -> no o_mem_req_valid, o_done one cycle after start, o_misalign=1.
REQ-041 Bench SHALL cover: i_start pulsed while in WAIT -> ignored; exactly one o_done pulse is produced.
